// File: rtl/lcd_char_writer_if.sv
// Message input and LCD pin bundle for the HD44780 character writer.
// The writer uses the master view. Whatever drives the message and
// watches the LCD pins uses the slave view.
interface lcd_char_writer_if;
  logic [255:0] chars;       // char k at bits [8k+7:8k]; 0..15 line 1, 16..31 line 2
  logic         lcd_rs;      // 0 = command, 1 = data
  logic         lcd_rw;      // write only, always 0
  logic         lcd_en;      // enable strobe
  logic [7:0]   lcd_data;    // 8-bit data bus
  logic         ready;       // controller initialised
  logic         frame_done;  // one-cycle pulse per refreshed frame

  modport master (
    input  chars,
    output lcd_rs, lcd_rw, lcd_en, lcd_data, ready, frame_done
  );

  modport slave (
    output chars,
    input  lcd_rs, lcd_rw, lcd_en, lcd_data, ready, frame_done
  );
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 16x2 write engine in 8-bit mode.
// After the power-up wait it sends the init command list once. It then
// refreshes both lines forever. Each frame is sent from a snapshot of the
// message that is captured when the frame starts.
// Every byte uses the same three phases:
//   setup (1 cycle), enable high (T_EN cycles), hold/wait (T_CMD or T_CLR cycles).
module lcd_char_writer #(
  parameter int unsigned T_POWERUP = 2_000_000,
  parameter int unsigned T_EN      = 25,
  parameter int unsigned T_CMD     = 2_500,
  parameter int unsigned T_CLR     = 100_000
) (
  input  logic              clk,
  input  logic              rstn,
  lcd_char_writer_if.master bus
);

  // Terminal counts for the shared 24-bit wait counter.
  localparam logic [23:0] PWRUP_LAST = 24'(T_POWERUP - 1);
  localparam logic [23:0] EN_LAST    = 24'(T_EN - 1);
  localparam logic [23:0] CMD_LAST   = 24'(T_CMD - 1);
  localparam logic [23:0] CLR_LAST   = 24'(T_CLR - 1);

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EN,
    PH_WAIT
  } phase_t;

  state_t       state_q, state_d;
  phase_t       phase_q, phase_d;
  logic [23:0]  cnt_q, cnt_d;
  logic [2:0]   init_idx_q, init_idx_d;
  logic [3:0]   char_idx_q, char_idx_d;
  logic [255:0] snap_q, snap_d;
  logic         rs_q, rs_d;
  logic         en_q, en_d;
  logic [7:0]   data_q, data_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic         load_byte;
  logic [23:0]  wait_last;

  // Init command list: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd = 8'h38;
      3'd3:             cmd = 8'h0C;
      3'd4:             cmd = 8'h01;
      default:          cmd = 8'h06;
    endcase
    return cmd;
  endfunction

  // Next-state logic: phase sequencing, byte advance and pin values.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    char_idx_d = char_idx_q;
    snap_d     = snap_q;
    rs_d       = rs_q;
    en_d       = en_q;
    data_d     = data_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    load_byte  = 1'b0;

    // The first function-set and the clear command need the long wait.
    if (state_q == ST_INIT && (init_idx_q == 3'd0 || init_idx_q == 3'd4)) begin
      wait_last = CLR_LAST;
    end else begin
      wait_last = CMD_LAST;
    end

    if (state_q == ST_PWRUP) begin
      if (cnt_q == PWRUP_LAST) begin
        cnt_d      = '0;
        state_d    = ST_INIT;
        init_idx_d = '0;
        load_byte  = 1'b1;
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end else begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_EN;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
        PH_EN: begin
          if (cnt_q == EN_LAST) begin
            phase_d = PH_WAIT;
            en_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        PH_WAIT: begin
          if (cnt_q == wait_last) begin
            cnt_d     = '0;
            load_byte = 1'b1;
            case (state_q)
              ST_INIT: begin
                if (init_idx_q == 3'd5) begin
                  state_d = ST_ADDR1;
                  ready_d = 1'b1;
                  snap_d  = bus.chars;
                end else begin
                  init_idx_d = init_idx_q + 3'd1;
                end
              end
              ST_ADDR1: begin
                state_d    = ST_LINE1;
                char_idx_d = '0;
              end
              ST_LINE1: begin
                if (char_idx_q == 4'd15) begin
                  state_d = ST_ADDR2;
                end else begin
                  char_idx_d = char_idx_q + 4'd1;
                end
              end
              ST_ADDR2: begin
                state_d    = ST_LINE2;
                char_idx_d = '0;
              end
              ST_LINE2: begin
                if (char_idx_q == 4'd15) begin
                  // The frame ends, and the next snapshot is taken on the same edge.
                  state_d = ST_ADDR1;
                  done_d  = 1'b1;
                  snap_d  = bus.chars;
                end else begin
                  char_idx_d = char_idx_q + 4'd1;
                end
              end
              default: state_d = ST_PWRUP;
            endcase
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        default: phase_d = PH_SETUP;
      endcase
    end

    // Present the next byte in its setup cycle. Chars come from the
    // snapshot, which has already been captured before LINE1 begins.
    if (load_byte) begin
      phase_d = PH_SETUP;
      en_d    = 1'b0;
      case (state_d)
        ST_INIT: begin
          rs_d   = 1'b0;
          data_d = init_cmd(init_idx_d);
        end
        ST_ADDR1: begin
          rs_d   = 1'b0;
          data_d = 8'h80;
        end
        ST_LINE1: begin
          rs_d   = 1'b1;
          data_d = snap_q[{1'b0, char_idx_d, 3'b000} +: 8];
        end
        ST_ADDR2: begin
          rs_d   = 1'b0;
          data_d = 8'hC0;
        end
        ST_LINE2: begin
          rs_d   = 1'b1;
          data_d = snap_q[{1'b1, char_idx_d, 3'b000} +: 8];
        end
        default: begin
          rs_d   = 1'b0;
          data_d = 8'h00;
        end
      endcase
    end
  end

  // Control and pin registers. Any reset restarts the full power-up wait.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_PWRUP;
      phase_q    <= PH_SETUP;
      cnt_q      <= '0;
      init_idx_q <= '0;
      char_idx_q <= '0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      char_idx_q <= char_idx_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // Message snapshot. It is always rewritten before first use, so it needs no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_en     = en_q;
  assign bus.lcd_data   = data_q;
  assign bus.ready      = ready_q;
  assign bus.frame_done = done_q;

endmodule
